vtx_xform4: RTL and testbench
=============================

VTX_XFORM4 -- requirements
Module: vtx_xform4

Interface
REQ-001 iClk  in  1  sole clock; all state changes on its rising edge.
REQ-002 iRst  in  1  asynchronous, active-high reset.
REQ-003 mat_valid  in  1  matrix word strobe; high for 16 consecutive cycles per matrix, one word per cycle, no backpressure.
REQ-004 mat_data  in  32  IEEE-754 single matrix word, row-major: word k = M[k/4][k%4].
REQ-005 mat_read_done  out  1  one-cycle pulse after the 16th matrix word is captured.
REQ-006 vtx_valid / vtx_ready  in / out  1 / 1  vertex word handshake; a word transfers when both are high.
REQ-007 vtx_data  in  32  vertex word, order x, y, z, w.
REQ-008 out_valid / out_ready  out / in  1 / 1  result word handshake; a word transfers when both are high.
REQ-009 out_data  out  32  transformed word, order x', y', z', w'.
REQ-010 mul_data_a_k, mul_data_b_k (k=0..3)  out  32  multiplier operands.
REQ-011 mul_a_stb_k, mul_b_stb_k / mul_a_ack_k, mul_b_ack_k  out / in  1  operand handshakes.
REQ-012 mul_result_k, mul_z_stb_k / mul_z_ack_k  in / out  32,1 / 1  multiplier result handshake.
REQ-013 add_data_a_j, add_data_b_j, add_*_stb_j, add_*_ack_j, add_result_j, add_z_stb_j, add_z_ack_j (j=0..2)  same directions and widths as the multiplier ports  adder ports.

Function
REQ-014 The block shall compute v' = M·v for each accepted vertex, where v' row r = sum over c of M[r][c]·v[c].
REQ-015 Matrix capture shall run independently of the transform FSM and shall write each word into the shadow bank of a two-bank 16×32 store.
REQ-016 On the 16th word the block shall set pend, pulse mat_read_done, and reset the word counter to 0.
REQ-017 If mat_valid drops before 16 words, the counter shall hold and capture shall resume on the next high cycle.
REQ-018 The bank select shall toggle (swap) only when pend=1 and the FSM is in IDLE or WAIT_V; the swap shall clear pend and set mat_loaded.
REQ-019 If a new matrix completes while pend=1, the new matrix shall overwrite the shadow bank (latest wins).
REQ-020 FSM states shall be IDLE, WAIT_V, LOAD_V, MUL, ADD_1, ADD_2, EMIT.
REQ-021 IDLE shall go to WAIT_V once mat_loaded=1.
REQ-022 In WAIT_V, vtx_ready shall be 1 only if no swap occurs that cycle; the first transfer shall go to LOAD_V.
REQ-023 In LOAD_V, vtx_ready shall be 1 until 4 words are held; the state shall then go to MUL with r=0.
REQ-024 In MUL, operands M[r][k] and v[k] shall drive multiplier k.
REQ-025 Each a/b stb shall stay high until its own ack is seen and shall then drop, tracked per operand.
REQ-026 When all four mul_z_stb_k are high in the same cycle, the block shall pulse every mul_z_ack_k, latch the products p0..p3, and go to ADD_1.
REQ-027 In ADD_1, adder0 shall compute p0+p1 and adder1 shall compute p2+p3, using the same stb/ack rules; when both z_stb are high the block shall ack, latch, and go to ADD_2.
REQ-028 In ADD_2, adder2 shall sum the two partial sums; on z_stb it shall ack and store y[r].
REQ-029 After ADD_2, the FSM shall go to MUL with r+1 if r<3, else to EMIT.
REQ-030 In EMIT, out_valid shall be 1 and out_data = y[idx]; idx shall advance on each transfer.
REQ-031 After the 4th transfer, EMIT shall go to WAIT_V.
REQ-032 out_data shall be held stable while out_valid=1 and out_ready=0.
REQ-033 The transform shall use only the active bank; a matrix arriving mid-vertex shall not affect that vertex.
REQ-034 The block shall perform no FP arithmetic internally; all rounding is the external units'.
REQ-035 Latency from the 4th vtx word to the first out_valid shall be 4×(mul+add+add handshake time)+1 cycle.

Reset
REQ-036 On iRst the block shall clear state to IDLE and zero the counters, pend, mat_loaded, bank select, r and idx.
REQ-037 On iRst all stb, z_ack, vtx_ready, out_valid and mat_read_done outputs shall be 0, and all data outputs shall be 0.
REQ-038 Reset asserted mid-operation shall abandon that operation; any in-flight FP result shall be ignored and not acked.
REQ-039 The matrix store contents shall need no reset.

Structure
REQ-040 A shared package render_pkg shall hold the FSM state enum, VEC_N=4, MAT_WORDS=16, and FP constants FP_ONE=32'h3F800000 and FP_ZERO=32'h0.
REQ-041 A single sub-module mat4_capture (counter, double bank, pend, swap) shall be instantiated once; the FSM and FP sequencing shall remain in vtx_xform4.

Verification (FP units are behavioural models with random 1–8-cycle ack and z_stb latency)
REQ-042 Identity M, v=(3F800000,40000000,40400000,3F800000) -> out x'=3F800000, y'=40000000, z'=40400000, w'=3F800000; mat_read_done pulses exactly once.
REQ-043 Translation M (row0 = 1,0,0,40A00000), v=(1,2,3,1) -> x'=40C00000, y'=40000000, z'=40400000, w'=3F800000.
REQ-044 Second matrix (all entries 0) streamed during vertex 1 compute -> vertex 1 uses the old M; vertex 2 outputs four 00000000 words.
REQ-045 out_ready held low for 10 cycles during EMIT -> out_data stable, no word lost or duplicated, exactly 4 transfers.
REQ-046 iRst pulsed during ADD_1 -> all outputs 0 the next cycle; a late add_z_stb is not acked; after re-loading, identity M gives the correct result.
REQ-047 mat_valid gapped (8 words, 3 idle cycles, 8 words) -> a single mat_read_done after word 16, and the matrix is captured correctly.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types and constants for the vertex transform block.
package render_pkg;

    localparam int DATA_W    = 32;
    localparam int VEC_N     = 4;
    localparam int MAT_WORDS = 16;

    localparam logic [DATA_W-1:0] FP_ONE  = 32'h3F800000;
    localparam logic [DATA_W-1:0] FP_ZERO = 32'h00000000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_V = 3'd1,
        S_LOAD_V = 3'd2,
        S_MUL    = 3'd3,
        S_ADD_1  = 3'd4,
        S_ADD_2  = 3'd5,
        S_EMIT   = 3'd6
    } xform_state_t;

endpackage

// File: rtl/mat4_capture.sv
// Matrix word capture into a double-buffered 4x4 store with deferred bank swap.
module mat4_capture
    import render_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic        mat_valid,
    input  logic [31:0] mat_data,
    input  logic        swap_ok,
    input  logic [1:0]  rd_row,
    output logic [31:0] rd_data_0,
    output logic [31:0] rd_data_1,
    output logic [31:0] rd_data_2,
    output logic [31:0] rd_data_3,
    output logic        mat_read_done,
    output logic        mat_loaded,
    output logic        swap
);

    logic [3:0]        cnt;
    logic              pend;
    logic              sel;
    logic              last_word;
    logic [DATA_W-1:0] bank0 [MAT_WORDS];
    logic [DATA_W-1:0] bank1 [MAT_WORDS];

    assign last_word = mat_valid && (cnt == 4'(MAT_WORDS - 1));
    assign swap      = pend && swap_ok;

    // Word counter, completion pulse, pending flag and active-bank select.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt           <= '0;
            pend          <= 1'b0;
            sel           <= 1'b0;
            mat_loaded    <= 1'b0;
            mat_read_done <= 1'b0;
        end else begin
            mat_read_done <= last_word;
            if (mat_valid) begin
                cnt <= cnt + 4'd1;
            end
            if (swap) begin
                sel        <= ~sel;
                mat_loaded <= 1'b1;
            end
            // A matrix finishing in the swap cycle lands in the bank that is
            // becoming active, so nothing is left pending in that case.
            if (swap) begin
                pend <= 1'b0;
            end else if (last_word) begin
                pend <= 1'b1;
            end
        end
    end

    // Writes always target the shadow bank; a newer matrix overwrites a pending one.
    always_ff @(posedge iClk) begin
        if (mat_valid) begin
            if (sel) begin
                bank0[cnt] <= mat_data;
            end else begin
                bank1[cnt] <= mat_data;
            end
        end
    end

    // Whole-row read from the active bank for the four multipliers.
    always_comb begin
        rd_data_0 = sel ? bank1[{rd_row, 2'd0}] : bank0[{rd_row, 2'd0}];
        rd_data_1 = sel ? bank1[{rd_row, 2'd1}] : bank0[{rd_row, 2'd1}];
        rd_data_2 = sel ? bank1[{rd_row, 2'd2}] : bank0[{rd_row, 2'd2}];
        rd_data_3 = sel ? bank1[{rd_row, 2'd3}] : bank0[{rd_row, 2'd3}];
    end

endmodule

// File: rtl/vtx_xform4.sv
// 4x4 matrix by vertex transform sequenced over external FP multipliers and adders.
module vtx_xform4
    import render_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic        mat_valid,
    input  logic [31:0] mat_data,
    output logic        mat_read_done,
    input  logic        vtx_valid,
    output logic        vtx_ready,
    input  logic [31:0] vtx_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] mul_data_a_0, mul_data_a_1, mul_data_a_2, mul_data_a_3,
    output logic [31:0] mul_data_b_0, mul_data_b_1, mul_data_b_2, mul_data_b_3,
    output logic        mul_a_stb_0, mul_a_stb_1, mul_a_stb_2, mul_a_stb_3,
    output logic        mul_b_stb_0, mul_b_stb_1, mul_b_stb_2, mul_b_stb_3,
    input  logic        mul_a_ack_0, mul_a_ack_1, mul_a_ack_2, mul_a_ack_3,
    input  logic        mul_b_ack_0, mul_b_ack_1, mul_b_ack_2, mul_b_ack_3,
    input  logic [31:0] mul_result_0, mul_result_1, mul_result_2, mul_result_3,
    input  logic        mul_z_stb_0, mul_z_stb_1, mul_z_stb_2, mul_z_stb_3,
    output logic        mul_z_ack_0, mul_z_ack_1, mul_z_ack_2, mul_z_ack_3,
    output logic [31:0] add_data_a_0, add_data_a_1, add_data_a_2,
    output logic [31:0] add_data_b_0, add_data_b_1, add_data_b_2,
    output logic        add_a_stb_0, add_a_stb_1, add_a_stb_2,
    output logic        add_b_stb_0, add_b_stb_1, add_b_stb_2,
    input  logic        add_a_ack_0, add_a_ack_1, add_a_ack_2,
    input  logic        add_b_ack_0, add_b_ack_1, add_b_ack_2,
    input  logic [31:0] add_result_0, add_result_1, add_result_2,
    input  logic        add_z_stb_0, add_z_stb_1, add_z_stb_2,
    output logic        add_z_ack_0, add_z_ack_1, add_z_ack_2
);

    xform_state_t      state, state_nxt;
    logic [1:0]        vcnt, r, idx;
    logic              swap, mat_loaded;
    logic              in_mul, in_add1, in_add2;
    logic              vtx_xfer, out_xfer, mul_fire, add1_fire, add2_fire;
    logic [DATA_W-1:0] mrow [VEC_N];
    logic [DATA_W-1:0] vin [VEC_N];
    logic [DATA_W-1:0] prod_p0 [VEC_N];
    logic [DATA_W-1:0] psum_p1 [2];
    logic [DATA_W-1:0] vout_p2 [VEC_N];
    logic [DATA_W-1:0] mul_a [VEC_N];
    logic [DATA_W-1:0] mul_b [VEC_N];
    logic [DATA_W-1:0] add_a [3];
    logic [DATA_W-1:0] add_b [3];
    logic [3:0]        m_a_stb, m_b_stb, m_a_ack, m_b_ack, m_z_stb, m_z_ack;
    logic [3:0]        m_a_done, m_b_done;
    logic [2:0]        d_a_stb, d_b_stb, d_a_ack, d_b_ack, d_z_stb, d_z_ack;
    logic [2:0]        d_a_done, d_b_done;

    mat4_capture u_capture (
        .iClk          (iClk),
        .iRst          (iRst),
        .mat_valid     (mat_valid),
        .mat_data      (mat_data),
        .swap_ok       ((state == S_IDLE) || (state == S_WAIT_V)),
        .rd_row        (r),
        .rd_data_0     (mrow[0]),
        .rd_data_1     (mrow[1]),
        .rd_data_2     (mrow[2]),
        .rd_data_3     (mrow[3]),
        .mat_read_done (mat_read_done),
        .mat_loaded    (mat_loaded),
        .swap          (swap)
    );

    assign m_a_ack = {mul_a_ack_3, mul_a_ack_2, mul_a_ack_1, mul_a_ack_0};
    assign m_b_ack = {mul_b_ack_3, mul_b_ack_2, mul_b_ack_1, mul_b_ack_0};
    assign m_z_stb = {mul_z_stb_3, mul_z_stb_2, mul_z_stb_1, mul_z_stb_0};
    assign d_a_ack = {add_a_ack_2, add_a_ack_1, add_a_ack_0};
    assign d_b_ack = {add_b_ack_2, add_b_ack_1, add_b_ack_0};
    assign d_z_stb = {add_z_stb_2, add_z_stb_1, add_z_stb_0};

    assign in_mul    = (state == S_MUL);
    assign in_add1   = (state == S_ADD_1);
    assign in_add2   = (state == S_ADD_2);
    assign mul_fire  = in_mul && (&m_z_stb);
    assign add1_fire = in_add1 && (&d_z_stb[1:0]);
    assign add2_fire = in_add2 && d_z_stb[2];
    assign vtx_xfer  = vtx_valid && vtx_ready;
    assign out_xfer  = out_valid && out_ready;

    // Strobes stay up until their own ack; z acks only in the owning state,
    // so results arriving after a reset are never acknowledged.
    assign m_a_stb = {4{in_mul}} & ~m_a_done;
    assign m_b_stb = {4{in_mul}} & ~m_b_done;
    assign m_z_ack = {4{mul_fire}};
    assign d_a_stb = {in_add2, {2{in_add1}}} & ~d_a_done;
    assign d_b_stb = {in_add2, {2{in_add1}}} & ~d_b_done;
    assign d_z_ack = {add2_fire, {2{add1_fire}}};

    assign {mul_a_stb_3, mul_a_stb_2, mul_a_stb_1, mul_a_stb_0} = m_a_stb;
    assign {mul_b_stb_3, mul_b_stb_2, mul_b_stb_1, mul_b_stb_0} = m_b_stb;
    assign {mul_z_ack_3, mul_z_ack_2, mul_z_ack_1, mul_z_ack_0} = m_z_ack;
    assign {add_a_stb_2, add_a_stb_1, add_a_stb_0} = d_a_stb;
    assign {add_b_stb_2, add_b_stb_1, add_b_stb_0} = d_b_stb;
    assign {add_z_ack_2, add_z_ack_1, add_z_ack_0} = d_z_ack;

    assign mul_data_a_0 = mul_a[0];
    assign mul_data_a_1 = mul_a[1];
    assign mul_data_a_2 = mul_a[2];
    assign mul_data_a_3 = mul_a[3];
    assign mul_data_b_0 = mul_b[0];
    assign mul_data_b_1 = mul_b[1];
    assign mul_data_b_2 = mul_b[2];
    assign mul_data_b_3 = mul_b[3];
    assign add_data_a_0 = add_a[0];
    assign add_data_a_1 = add_a[1];
    assign add_data_a_2 = add_a[2];
    assign add_data_b_0 = add_b[0];
    assign add_data_b_1 = add_b[1];
    assign add_data_b_2 = add_b[2];

    // Operand buses are driven only in the owning state, zero otherwise.
    always_comb begin
        for (int k = 0; k < VEC_N; k++) begin
            mul_a[k] = in_mul ? mrow[k] : FP_ZERO;
            mul_b[k] = in_mul ? vin[k]  : FP_ZERO;
        end
        add_a[0] = in_add1 ? prod_p0[0] : FP_ZERO;
        add_b[0] = in_add1 ? prod_p0[1] : FP_ZERO;
        add_a[1] = in_add1 ? prod_p0[2] : FP_ZERO;
        add_b[1] = in_add1 ? prod_p0[3] : FP_ZERO;
        add_a[2] = in_add2 ? psum_p1[0] : FP_ZERO;
        add_b[2] = in_add2 ? psum_p1[1] : FP_ZERO;
        out_data = (state == S_EMIT) ? vout_p2[idx] : FP_ZERO;
    end

    // State register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; vertex intake is blocked in a swap cycle.
    always_comb begin
        state_nxt = state;
        vtx_ready = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (mat_loaded) state_nxt = S_WAIT_V;
            end
            S_WAIT_V: begin
                vtx_ready = !swap;
                if (vtx_valid && !swap) state_nxt = S_LOAD_V;
            end
            S_LOAD_V: begin
                vtx_ready = 1'b1;
                if (vtx_valid && (vcnt == 2'd3)) state_nxt = S_MUL;
            end
            S_MUL: begin
                if (mul_fire) state_nxt = S_ADD_1;
            end
            S_ADD_1: begin
                if (add1_fire) state_nxt = S_ADD_2;
            end
            S_ADD_2: begin
                if (add2_fire) state_nxt = (r == 2'd3) ? S_EMIT : S_MUL;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready && (idx == 2'd3)) state_nxt = S_WAIT_V;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Vertex word, row and emit counters; all wrap naturally at four.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            vcnt <= '0;
            r    <= '0;
            idx  <= '0;
        end else begin
            if (vtx_xfer) vcnt <= vcnt + 2'd1;
            if (vtx_xfer && (state == S_LOAD_V) && (vcnt == 2'd3)) begin
                r <= '0;
            end else if (add2_fire) begin
                r <= r + 2'd1;
            end
            if (out_xfer) idx <= idx + 2'd1;
        end
    end

    // Per-operand handshake bookkeeping, cleared whenever a stage completes.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            m_a_done <= '0;
            m_b_done <= '0;
            d_a_done <= '0;
            d_b_done <= '0;
        end else if (mul_fire || add1_fire || add2_fire) begin
            m_a_done <= '0;
            m_b_done <= '0;
            d_a_done <= '0;
            d_b_done <= '0;
        end else begin
            m_a_done <= m_a_done | (m_a_stb & m_a_ack);
            m_b_done <= m_b_done | (m_b_stb & m_b_ack);
            d_a_done <= d_a_done | (d_a_stb & d_a_ack);
            d_b_done <= d_b_done | (d_b_stb & d_b_ack);
        end
    end

    // Datapath holding registers: vertex, products, partial sums, row results.
    always_ff @(posedge iClk) begin
        if (vtx_xfer) vin[vcnt] <= vtx_data;
        if (mul_fire) begin
            prod_p0[0] <= mul_result_0;
            prod_p0[1] <= mul_result_1;
            prod_p0[2] <= mul_result_2;
            prod_p0[3] <= mul_result_3;
        end
        if (add1_fire) begin
            psum_p1[0] <= add_result_0;
            psum_p1[1] <= add_result_1;
        end
        if (add2_fire) vout_p2[r] <= add_result_2;
    end

endmodule

// File: tb/tb_vtx_xform4.sv
// Directed bench for vtx_xform4 with behavioural FP multiplier/adder models.
module tb_vtx_xform4;

    logic        clk, rst, flush;
    logic        mat_valid, mat_read_done;
    logic [31:0] mat_data;
    logic        vtx_valid, vtx_ready;
    logic [31:0] vtx_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;

    // units 0..3 are multipliers, 4..6 are adders 0..2
    logic [31:0] u_da [7];
    logic [31:0] u_db [7];
    logic        u_as [7];
    logic        u_bs [7];
    logic        u_aa [7];
    logic        u_ba [7];
    logic [31:0] u_res [7];
    logic        u_zs [7];
    logic        u_za [7];

    logic [31:0] mat_buf [16];
    logic [31:0] outq [$];
    int          total, bad, done_cnt;

    vtx_xform4 dut (
        .iClk(clk), .iRst(rst),
        .mat_valid(mat_valid), .mat_data(mat_data), .mat_read_done(mat_read_done),
        .vtx_valid(vtx_valid), .vtx_ready(vtx_ready), .vtx_data(vtx_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mul_data_a_0(u_da[0]), .mul_data_a_1(u_da[1]), .mul_data_a_2(u_da[2]), .mul_data_a_3(u_da[3]),
        .mul_data_b_0(u_db[0]), .mul_data_b_1(u_db[1]), .mul_data_b_2(u_db[2]), .mul_data_b_3(u_db[3]),
        .mul_a_stb_0(u_as[0]), .mul_a_stb_1(u_as[1]), .mul_a_stb_2(u_as[2]), .mul_a_stb_3(u_as[3]),
        .mul_b_stb_0(u_bs[0]), .mul_b_stb_1(u_bs[1]), .mul_b_stb_2(u_bs[2]), .mul_b_stb_3(u_bs[3]),
        .mul_a_ack_0(u_aa[0]), .mul_a_ack_1(u_aa[1]), .mul_a_ack_2(u_aa[2]), .mul_a_ack_3(u_aa[3]),
        .mul_b_ack_0(u_ba[0]), .mul_b_ack_1(u_ba[1]), .mul_b_ack_2(u_ba[2]), .mul_b_ack_3(u_ba[3]),
        .mul_result_0(u_res[0]), .mul_result_1(u_res[1]), .mul_result_2(u_res[2]), .mul_result_3(u_res[3]),
        .mul_z_stb_0(u_zs[0]), .mul_z_stb_1(u_zs[1]), .mul_z_stb_2(u_zs[2]), .mul_z_stb_3(u_zs[3]),
        .mul_z_ack_0(u_za[0]), .mul_z_ack_1(u_za[1]), .mul_z_ack_2(u_za[2]), .mul_z_ack_3(u_za[3]),
        .add_data_a_0(u_da[4]), .add_data_a_1(u_da[5]), .add_data_a_2(u_da[6]),
        .add_data_b_0(u_db[4]), .add_data_b_1(u_db[5]), .add_data_b_2(u_db[6]),
        .add_a_stb_0(u_as[4]), .add_a_stb_1(u_as[5]), .add_a_stb_2(u_as[6]),
        .add_b_stb_0(u_bs[4]), .add_b_stb_1(u_bs[5]), .add_b_stb_2(u_bs[6]),
        .add_a_ack_0(u_aa[4]), .add_a_ack_1(u_aa[5]), .add_a_ack_2(u_aa[6]),
        .add_b_ack_0(u_ba[4]), .add_b_ack_1(u_ba[5]), .add_b_ack_2(u_ba[6]),
        .add_result_0(u_res[4]), .add_result_1(u_res[5]), .add_result_2(u_res[6]),
        .add_z_stb_0(u_zs[4]), .add_z_stb_1(u_zs[5]), .add_z_stb_2(u_zs[6]),
        .add_z_ack_0(u_za[4]), .add_z_ack_1(u_za[5]), .add_z_ack_2(u_za[6])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        logic        s;
        int          e;
        real         m;
        logic [22:0] f;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        m = s ? -x : x;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        f = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e), f};
    endfunction

    // Behavioural FP units: random 1-8 cycle operand ack and result latency.
    for (genvar g = 0; g < 7; g++) begin : gen_unit
        logic        have_a, have_b, aa, ba, zs;
        logic [31:0] av, bv, res;
        int          aw, bw, zw;
        assign u_aa[g]  = aa;
        assign u_ba[g]  = ba;
        assign u_zs[g]  = zs;
        assign u_res[g] = res;
        always @(posedge clk) begin
            if (flush) begin
                have_a <= 1'b0; have_b <= 1'b0;
                aa <= 1'b0; ba <= 1'b0; zs <= 1'b0; res <= 32'h0;
                av <= 32'h0; bv <= 32'h0;
                aw <= int'($urandom_range(8, 1));
                bw <= int'($urandom_range(8, 1));
                zw <= int'($urandom_range(8, 1));
            end else begin
                aa <= 1'b0;
                ba <= 1'b0;
                if (u_as[g] && !have_a) begin
                    if (aw <= 1) begin
                        aa <= 1'b1; have_a <= 1'b1; av <= u_da[g];
                        aw <= int'($urandom_range(8, 1));
                    end else aw <= aw - 1;
                end
                if (u_bs[g] && !have_b) begin
                    if (bw <= 1) begin
                        ba <= 1'b1; have_b <= 1'b1; bv <= u_db[g];
                        bw <= int'($urandom_range(8, 1));
                    end else bw <= bw - 1;
                end
                if (have_a && have_b && !zs) begin
                    if (zw <= 1) begin
                        zs  <= 1'b1;
                        res <= (g < 4) ? r2f(f2r(av) * f2r(bv)) : r2f(f2r(av) + f2r(bv));
                        zw  <= int'($urandom_range(8, 1));
                    end else zw <= zw - 1;
                end
                if (zs && u_za[g]) begin
                    zs <= 1'b0; have_a <= 1'b0; have_b <= 1'b0;
                end
            end
        end
    end

    always @(posedge clk) if (mat_read_done) done_cnt <= done_cnt + 1;
    always @(posedge clk) if (out_valid && out_ready) outq.push_back(out_data);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_identity();
        for (int i = 0; i < 16; i++) mat_buf[i] = (i % 5 == 0) ? 32'h3F800000 : 32'h0;
    endtask

    task automatic load_words(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            mat_valid = 1'b1;
            mat_data  = mat_buf[i];
            tick(1);
        end
        mat_valid = 1'b0;
        mat_data  = 32'h0;
    endtask

    task automatic send_vertex(input logic [31:0] x, y, z, w);
        logic [31:0] wd [4];
        int n;
        wd[0] = x; wd[1] = y; wd[2] = z; wd[3] = w;
        for (int i = 0; i < 4; i++) begin
            vtx_valid = 1'b1;
            vtx_data  = wd[i];
            n = 0;
            while (!vtx_ready && n < 500) begin tick(1); n++; end
            if (n >= 500) check("vtx_ready_timeout", 32'(n), 32'd0);
            tick(1);
        end
        vtx_valid = 1'b0;
        vtx_data  = 32'h0;
    endtask

    task automatic expect_vertex(input string tag, input logic [31:0] e0, e1, e2, e3);
        logic [31:0] ex [4];
        int n;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        n = 0;
        while (outq.size() < 4 && n < 3000) begin tick(1); n++; end
        check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
        tick(5);
        check({tag, "_count"}, 32'(outq.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_w%0d", tag, i), (outq.size() > i) ? outq[i] : 32'hDEADBEEF, ex[i]);
    endtask

    initial begin
        int  d0, n;
        bit  stable, saw_late, acked_late;
        logic [31:0] held;
        total = 0; bad = 0; done_cnt = 0;
        rst = 1'b0; flush = 1'b1;
        mat_valid = 1'b0; mat_data = 32'h0;
        vtx_valid = 1'b0; vtx_data = 32'h0; out_ready = 1'b1;
        #2 rst = 1'b1;
        tick(3);
        check("rst_mat_read_done", 32'(mat_read_done), 32'd0);
        check("rst_vtx_ready", 32'(vtx_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_mul_a_stb_0", 32'(u_as[0]), 32'd0);
        check("rst_mul_data_a_0", u_da[0], 32'h0);
        check("rst_add_b_stb_2", 32'(u_bs[6]), 32'd0);
        rst = 1'b0; flush = 1'b0;
        tick(2);

        // identity matrix, single completion pulse
        set_identity();
        load_words(0, 15);
        tick(4);
        check("ident_done_cnt", 32'(done_cnt), 32'd1);
        outq.delete();
        send_vertex(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000);
        expect_vertex("ident", 32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000);
        check("ident_done_once", 32'(done_cnt), 32'd1);

        // translation matrix
        set_identity();
        mat_buf[3] = 32'h40A00000;
        load_words(0, 15);
        tick(4);
        outq.delete();
        send_vertex(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000);
        expect_vertex("xlate", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h3F800000);

        // zero matrix streamed while vertex 1 computes with the old matrix
        outq.delete();
        send_vertex(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000);
        for (int i = 0; i < 16; i++) mat_buf[i] = 32'h0;
        load_words(0, 15);
        expect_vertex("old_m", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h3F800000);
        check("zero_done_cnt", 32'(done_cnt), 32'd3);
        outq.delete();
        send_vertex(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000);
        expect_vertex("zero_m", 32'h0, 32'h0, 32'h0, 32'h0);

        // output backpressure during emit
        set_identity();
        load_words(0, 15);
        tick(4);
        outq.delete();
        out_ready = 1'b0;
        send_vertex(32'h40800000, 32'h40A00000, 32'h40C00000, 32'h3F800000);
        n = 0;
        while (!out_valid && n < 3000) begin tick(1); n++; end
        check("stall_valid_seen", 32'(out_valid), 32'd1);
        held = out_data;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (out_data !== held || !out_valid) stable = 1'b0;
        end
        check("stall_data_stable", 32'(stable), 32'd1);
        check("stall_held_word", held, 32'h40800000);
        check("stall_no_xfer", 32'(outq.size()), 32'd0);
        out_ready = 1'b1;
        expect_vertex("stall", 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h3F800000);

        // reset while adder 0 holds both operands
        outq.delete();
        send_vertex(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000);
        n = 0;
        while (!(gen_unit[4].have_a && gen_unit[4].have_b && !u_zs[4]) && n < 3000) begin
            tick(1); n++;
        end
        check("add1_reached", 32'(n < 3000), 32'd1);
        rst = 1'b1;
        saw_late = 1'b0; acked_late = 1'b0;
        tick(1);
        check("midrst_vtx_ready", 32'(vtx_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_add_a_stb_0", 32'(u_as[4]), 32'd0);
        check("midrst_add_data_a_0", u_da[4], 32'h0);
        check("midrst_mul_a_stb_0", 32'(u_as[0]), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (u_zs[4]) saw_late = 1'b1;
            if (u_za[4]) acked_late = 1'b1;
            tick(1);
        end
        check("late_z_stb_seen", 32'(saw_late), 32'd1);
        check("late_z_not_acked", 32'(acked_late), 32'd0);
        check("midrst_no_output", 32'(outq.size()), 32'd0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(1);

        // gapped identity reload after reset
        set_identity();
        d0 = done_cnt;
        load_words(0, 7);
        tick(3);
        check("gap_no_early_done", 32'(done_cnt - d0), 32'd0);
        load_words(8, 15);
        tick(4);
        check("gap_single_done", 32'(done_cnt - d0), 32'd1);
        outq.delete();
        send_vertex(32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000);
        expect_vertex("gap", 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
